// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between config logic and clk_div_ctrl.
// master = register side, slave = divider controller.
interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             en_i;
    logic             req_i;
    logic [CNT_W-1:0] div_i;
    logic             ack_o;
    logic             busy_o;
    logic             err_o;
    logic             tick_o;
    logic             clk_o;

    modport master (
        output en_i,
        output req_i,
        output div_i,
        input  ack_o,
        input  busy_o,
        input  err_o,
        input  tick_o,
        input  clk_o
    );

    modport slave (
        input  en_i,
        input  req_i,
        input  div_i,
        output ack_o,
        output busy_o,
        output err_o,
        output tick_o,
        output clk_o
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider with run-time ratio changes.
// CLK_DIV_ODD_DUTY50_EN: falling-edge stretch gives 50% duty for odd N.
module clk_div_ctrl #(
    parameter int CNT_W   = 8,
    parameter int DIV_RST = 3
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    clk_div_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] N_RST = CNT_W'(DIV_RST);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_act;
    logic [CNT_W-1:0] n_pend;
    logic             clk_q;
    logic             tick_q;
    logic             ack_q;
    logic             busy_q;
    logic             err_q;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hi_lim;
    logic             last;
    logic             hi_nxt;
    logic             req_ok;
    logic             req_bad;

    assign cnt_inc = cnt + ONE;
    assign last    = (cnt == n_act - ONE);
    assign hi_nxt  = (cnt_inc < hi_lim);

    // A request is refused for a ratio below 2 or while one is queued.
    assign req_ok  = bus.req_i && (bus.div_i >= TWO) && (state != PEND);
    assign req_bad = bus.req_i && !req_ok;

`ifdef CLK_DIV_ODD_DUTY50_EN
    assign hi_lim = n_act >> 1;
`else
    assign hi_lim = (n_act >> 1) + {{(CNT_W-1){1'b0}}, n_act[0]};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= STOP;
            cnt    <= '0;
            n_act  <= N_RST;
            n_pend <= N_RST;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= req_bad;
            unique case (state)
                STOP: begin
                    if (req_ok) begin
                        n_act  <= bus.div_i;
                        n_pend <= bus.div_i;
                        ack_q  <= 1'b1;
                    end
                    if (bus.en_i) begin
                        state  <= RUN;
                        cnt    <= '0;
                        clk_q  <= 1'b1;
                        tick_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (last) begin
                        cnt <= '0;
                        if (bus.en_i) begin
                            clk_q  <= 1'b1;
                            tick_q <= 1'b1;
                        end else begin
                            state <= STOP;
                            clk_q <= 1'b0;
                        end
                    end else begin
                        cnt   <= cnt_inc;
                        clk_q <= hi_nxt;
                    end
                    if (req_ok) begin
                        // Stopping at this boundary: nothing left to wait for.
                        if (last && !bus.en_i) begin
                            n_act  <= bus.div_i;
                            n_pend <= bus.div_i;
                            ack_q  <= 1'b1;
                        end else begin
                            n_pend <= bus.div_i;
                            busy_q <= 1'b1;
                            state  <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (last) begin
                        cnt    <= '0;
                        n_act  <= n_pend;
                        ack_q  <= 1'b1;
                        busy_q <= 1'b0;
                        if (bus.en_i) begin
                            state  <= RUN;
                            clk_q  <= 1'b1;
                            tick_q <= 1'b1;
                        end else begin
                            state <= STOP;
                            clk_q <= 1'b0;
                        end
                    end else begin
                        cnt   <= cnt_inc;
                        clk_q <= hi_nxt;
                    end
                end
                default: begin
                    state <= STOP;
                    cnt   <= '0;
                    clk_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    // Half-cycle stretch of the high phase for odd ratios only.
    logic clk_f;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_f <= 1'b0;
        end else begin
            clk_f <= clk_q & n_act[0];
        end
    end

    assign bus.clk_o = clk_q | clk_f;
`else
    assign bus.clk_o = clk_q;
`endif

    assign bus.tick_o = tick_q;
    assign bus.ack_o  = ack_q;
    assign bus.busy_o = busy_q;
    assign bus.err_o  = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic
// checked against a period-level reference model.
module tb_clk_div_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    clk_div_ctrl_if #(.CNT_W(8)) bus ();

    clk_div_ctrl #(
        .CNT_W  (8),
        .DIV_RST(3)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: running flag, position in period, ratio, queued ratio.
    bit m_run;
    int m_pos;
    int m_n;
    bit m_pv;
    int m_pend;
    bit m_ack;
    bit m_err;

    function automatic void m_reset();
        m_run  = 0;
        m_pos  = 0;
        m_n    = 3;
        m_pv   = 0;
        m_pend = 3;
        m_ack  = 0;
        m_err  = 0;
    endfunction

    function automatic void m_step(input logic en, input logic req,
                                   input logic [7:0] div);
        bit ok;
        bit was_pv;
        was_pv = m_pv;
        ok     = req && (int'(div) >= 2) && !was_pv;
        m_err  = req && !ok;
        m_ack  = 0;
        if (!m_run) begin
            if (ok) begin
                m_n   = int'(div);
                m_ack = 1;
            end
            if (en) begin
                m_run = 1;
                m_pos = 0;
            end
        end else if (m_pos == m_n - 1) begin
            if (was_pv) begin
                m_n   = m_pend;
                m_pv  = 0;
                m_ack = 1;
            end
            m_pos = 0;
            m_run = en;
            if (ok && !en) begin
                m_n   = int'(div);
                m_ack = 1;
            end else if (ok) begin
                m_pend = int'(div);
                m_pv   = 1;
            end
        end else begin
            m_pos = m_pos + 1;
            if (ok) begin
                m_pend = int'(div);
                m_pv   = 1;
            end
        end
    endfunction

    function automatic logic [4:0] m_out();
        logic c;
        logic t;
        c = m_run && (m_pos < (m_n + 1) / 2);
        t = m_run && (m_pos == 0);
        return {c, t, m_ack, m_pv, m_err};
    endfunction

    function automatic logic [4:0] dut_out();
        return {bus.clk_o, bus.tick_o, bus.ack_o, bus.busy_o, bus.err_o};
    endfunction

    // Inputs change at the falling edge; outputs are read at the next one.
    task automatic cyc(input logic en, input logic req, input logic [7:0] div);
        bus.en_i  = en;
        bus.req_i = req;
        bus.div_i = div;
        m_step(en, req, div);
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.en_i  = 1'b0;
        bus.req_i = 1'b0;
        bus.div_i = 8'd0;
        rst_n     = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        total++;
        if (dut_out() !== 5'b00000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=00000", dut_out());
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 8'd0);
        total++;
        if (dut_out() !== m_out()) begin
            bad++;
            $display("FAIL reset_idle got=%b want=%b", dut_out(), m_out());
        end
    endtask

    task automatic test_run();
        logic [8:0] cpat;
        logic [8:0] tpat;
        cpat = 9'b110110110;
        tpat = 9'b100100100;
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0, 8'd0);
            total++;
            if (bus.clk_o !== cpat[8-i] || bus.tick_o !== tpat[8-i]) begin
                bad++;
                $display("FAIL run_n3 i=%0d got clk=%b tick=%b want clk=%b tick=%b",
                         i, bus.clk_o, bus.tick_o, cpat[8-i], tpat[8-i]);
            end
        end
    endtask

    task automatic test_ratio_change();
        bit         found;
        logic [2:0] cpat;
        cpat = 3'b100;
        cyc(1'b1, 1'b0, 8'd0);
        cyc(1'b1, 1'b1, 8'd4);
        total++;
        if (bus.busy_o !== 1'b1 || bus.ack_o !== 1'b0) begin
            bad++;
            $display("FAIL change_busy got busy=%b ack=%b want busy=1 ack=0",
                     bus.busy_o, bus.ack_o);
        end
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            cyc(1'b1, 1'b0, 8'd0);
            total++;
            if (dut_out() !== m_out()) begin
                bad++;
                $display("FAIL change_model i=%0d got=%b want=%b", i, dut_out(), m_out());
            end
            if (bus.ack_o === 1'b1) begin
                found = 1;
                total++;
                if (bus.tick_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.clk_o !== 1'b1) begin
                    bad++;
                    $display("FAIL change_ack got tick=%b busy=%b clk=%b want 1 0 1",
                             bus.tick_o, bus.busy_o, bus.clk_o);
                end
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL change_timeout got no ack want ack within 6 cycles");
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 8'd0);
            total++;
            if (bus.clk_o !== cpat[2-i] || bus.tick_o !== 1'b0) begin
                bad++;
                $display("FAIL change_n4 i=%0d got clk=%b tick=%b want clk=%b tick=0",
                         i, bus.clk_o, bus.tick_o, cpat[2-i]);
            end
        end
    endtask

    task automatic test_reject();
        cyc(1'b1, 1'b1, 8'd1);
        total++;
        if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.ack_o !== 1'b0) begin
            bad++;
            $display("FAIL reject_small got err=%b busy=%b ack=%b want 1 0 0",
                     bus.err_o, bus.busy_o, bus.ack_o);
        end
        cyc(1'b1, 1'b1, 8'd5);
        cyc(1'b1, 1'b1, 8'd6);
        total++;
        if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL reject_busy got err=%b busy=%b want err=1 busy=1",
                     bus.err_o, bus.busy_o);
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 8'd0);
            total++;
            if (dut_out() !== m_out()) begin
                bad++;
                $display("FAIL reject_model i=%0d got=%b want=%b", i, dut_out(), m_out());
            end
        end
    endtask

    task automatic test_stop_restart();
        logic [6:0] spat;
        bit         hit;
        spat = 7'b1000000;
        hit  = 0;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (m_run && m_pos == 1 && m_n == 5) begin
                hit = 1;
            end else begin
                cyc(1'b1, 1'b0, 8'd0);
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL stop_reach got pos=%0d n=%0d want pos=1 n=5", m_pos, m_n);
        end
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 8'd0);
            total++;
            if (bus.clk_o !== spat[6-i] || dut_out() !== m_out()) begin
                bad++;
                $display("FAIL stop_tail i=%0d got=%b want clk=%b model=%b",
                         i, dut_out(), spat[6-i], m_out());
            end
        end
        cyc(1'b1, 1'b0, 8'd0);
        total++;
        if (bus.clk_o !== 1'b1 || bus.tick_o !== 1'b1) begin
            bad++;
            $display("FAIL restart got clk=%b tick=%b want 1 1", bus.clk_o, bus.tick_o);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (dut_out() !== 5'b00000) begin
            bad++;
            $display("FAIL async_reset got=%b want=00000", dut_out());
        end
        bus.en_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 8'd0);
            total++;
            if (dut_out() !== 5'b00000) begin
                bad++;
                $display("FAIL post_reset_stop i=%0d got=%b want=00000", i, dut_out());
            end
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 8'd0);
            total++;
            if (dut_out() !== m_out()) begin
                bad++;
                $display("FAIL post_reset_n3 i=%0d got=%b want=%b", i, dut_out(), m_out());
            end
        end
    endtask

    task automatic test_extremes();
        bus.en_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 8'd0);
        end
        cyc(1'b0, 1'b1, 8'd2);
        total++;
        if (bus.ack_o !== 1'b1 || bus.err_o !== 1'b0 || bus.clk_o !== 1'b0) begin
            bad++;
            $display("FAIL stop_load_ack got ack=%b err=%b clk=%b want 1 0 0",
                     bus.ack_o, bus.err_o, bus.clk_o);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 8'd0);
            total++;
            if (bus.clk_o !== ((i % 2) == 0) || dut_out() !== m_out()) begin
                bad++;
                $display("FAIL run_n2 i=%0d got=%b want=%b", i, dut_out(), m_out());
            end
        end
        cyc(1'b1, 1'b1, 8'd255);
        for (int i = 0; i < 270; i++) begin
            cyc(1'b1, (i == 100), 8'd0);
            total++;
            if (dut_out() !== m_out()) begin
                bad++;
                $display("FAIL n255 i=%0d got=%b want=%b", i, dut_out(), m_out());
            end
        end
    endtask

    task automatic test_random();
        logic       en;
        logic       req;
        logic [7:0] div;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            req = ($urandom_range(0, 7) == 0);
            div = 8'($urandom_range(0, 9));
            cyc(en, req, div);
            total++;
            if (dut_out() !== m_out()) begin
                bad++;
                $display("FAIL random i=%0d en=%b req=%b div=%0d got=%b want=%b",
                         i, en, req, div, dut_out(), m_out());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_run();
        test_ratio_change();
        test_reject();
        test_stop_restart();
        test_async_reset();
        test_extremes();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Programmable clock-divider controller: generates a divided clock `clk_o` of ratio N (2..2^CNT_W-1) from `clk_i`, and sequences start, stop and ratio changes so that no runt or glitched period ever appears on `clk_o`. It sits between the register/config logic and the fixed-ratio divider datapath. It replaces per-ratio dividers where the ratio must change at run time.

## Interface
- `CNT_W`, 8, width of ratio and period counter
- `DIV_RST`, 3, active ratio after reset (must be ≥2)
- `clk_i  in  1`  source clock; all logic on its rising edge (plus falling edge when the odd-duty feature is compiled in)
- `rst_ni  in  1`  reset, asynchronous, active-low
- `en_i  in  1`  run request; level
- `req_i  in  1`  ratio-change request; single-cycle pulse
- `div_i  in  CNT_W`  requested ratio; sampled only when `req_i`=1
- `ack_o  out  1`  one-cycle pulse: requested ratio is now active
- `busy_o  out  1`  a ratio change is pending
- `err_o  out  1`  one-cycle pulse: request rejected
- `tick_o  out  1`  one-cycle pulse in the first `clk_i` cycle of every `clk_o` period
- `clk_o  out  1`  divided clock, registered

## Operation
- Reset values: `clk_o`=0, `tick_o`=0, `ack_o`=0, `busy_o`=0, `err_o`=0, period counter `cnt`=0, active ratio `N`=DIV_RST, pending ratio=DIV_RST, state=STOP.
- States:
  - STOP: `clk_o` low.
  - RUN: `cnt` counts 0..N-1 and wraps.
  - PEND: as RUN, with a ratio change queued.
- STOP→RUN when `en_i`=1 is sampled. The cycle after that edge is `cnt`=0, with `clk_o`=1 and `tick_o`=1.
- RUN/PEND with `en_i`=0: the current period completes (through `cnt`=N-1), then the block enters STOP. No truncated high or low phase.
- Duty cycle: `clk_o`=1 while `cnt` < H, where H = ceil(N/2) (N=3: 1,1,0; N=4: 1,1,0,0; N=5: 1,1,1,0,0).
- Ratio change:
  - `req_i` with `div_i` ≥2 in STOP: load `N` immediately; `ack_o` pulses the next cycle.
  - In RUN: capture `div_i` into the pending register, set `busy_o`, go to PEND.
  - In PEND, at the `cnt`=N-1 cycle, `N` takes the pending value and `cnt` wraps to 0. `ack_o` pulses in that new `cnt`=0 cycle together with `tick_o`. `busy_o` clears in the same cycle, and the state returns to RUN.
- Rejects: `req_i` with `div_i` < 2, or `req_i` while `busy_o`=1, raises `err_o` the next cycle. Active and pending ratios are unchanged.
- `en_i` falls while in PEND: the pending ratio is still applied at the period end, `ack_o` pulses, and the block enters STOP (no `tick_o`, `clk_o` stays 0).
- `req_i` in the same cycle as the `cnt`=N-1 wrap while in RUN: the request is queued for the following period boundary, not the current one.
- Counter width: `cnt` is CNT_W bits. It wraps only by comparison to N-1 and never overflows.
- An asynchronous reset mid-operation forces all reset values immediately. `clk_o` drops without completing the period; this is accepted.

## Timing
- Latency from `en_i` sampled high to `clk_o` rising: one cycle. `tick_o` is coincident with every `clk_o` rising edge.
- Latency from `req_i` in STOP to `ack_o`: one cycle.
- Latency from `req_i` in RUN to `ack_o`: the remaining cycles of the current period plus 1. Maximum is N cycles.
- All outputs are registered; none are combinational from inputs.
- `err_o` and `ack_o` never assert in the same cycle for the same request.

## Configuration
- `CLK_DIV_ODD_DUTY50_EN` defined:
  - For odd N, `clk_o` is extended by a falling-edge flop so the high time is exactly N/2 `clk_i` periods (N=3: high 1.5 cycles, low 1.5 cycles).
  - Even N is unchanged. `tick_o` and handshakes stay on rising edges.
- Not defined: rising-edge logic only; odd-N high time is ceil(N/2) cycles as described in Operation.

## Test plan
- Reset, `en_i`=1, default N=3 → `clk_o` pattern 1,1,0 repeating. `tick_o` pulses every 3 cycles. First high is one cycle after `en_i` is sampled.
- While running at N=3, pulse `req_i` with `div_i`=4 mid-period → `busy_o`=1 until the period end. `ack_o` and `tick_o` then pulse together, followed by `clk_o` 1,1,0,0.
- `req_i` with `div_i`=1, and separately `req_i` with `busy_o`=1 → `err_o` pulses one cycle later. Ratio unchanged and `clk_o` period unchanged.
- Drop `en_i` at `cnt`=1 with N=5 → the period completes (1,1,1,0,0), then `clk_o` stays 0. Re-assert `en_i` → a clean restart with `cnt`=0.
- Assert `rst_ni`=0 mid-high phase → all outputs go to 0 asynchronously. After release, N=3 and state is STOP.
- With `CLK_DIV_ODD_DUTY50_EN` and N=3 → `clk_o` high for 15 ns and low for 15 ns with a 10 ns `clk_i` period. With N=4 → 20 ns / 20 ns.
